regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised multi-port integer register file with a built-in scoreboard. Successor to the single-issue CPU register file.
- Provides NRD combinational read ports and NWR write-back ports, with same-cycle write-to-read bypass.
- Tracks a per-register busy bit for in-flight producers, and runs a post-reset zero-sweep of the storage array.
- Sits between decode/issue (reads, busy checks, destination marking) and the write-back stages (ALU, load, atomic).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of two, >=2).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- AW, $clog2(NREGS), address width (localparam, derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN].
- rd_busy  out  NRD  1 = port i register still has a pending producer.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- issue_en  in  1  mark issue_rd busy at the next edge.
- issue_rd  in  AW  destination register being issued.
- flush  in  1  clear all busy bits (pipeline flush).
- ready  out  1  1 = sweep complete and file usable.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=CLEAR, sweep counter=0, busy=all 0, ready=0.
  - While in CLEAR, rd_data=0 and rd_busy=0; all wr_en, issue_en and flush inputs are ignored.
- FSM, two states:
  - CLEAR: each cycle writes 0 to entry cnt, then cnt<=cnt+1. When cnt==NREGS-1, the next state is RUN.
  - ready rises exactly NREGS rising edges after reset deasserts.
  - A reset asserted mid-sweep restarts the sweep at 0.
  - RUN: ready=1. No exit except reset.
- Register 0:
  - Reads always return 0, and rd_busy is always 0.
  - Writes and issues to address 0 are ignored.
- Writes (RUN):
  - Each port with wr_en=1 and addr!=0 commits wr_data at the edge.
  - If several ports target the same address in one cycle, the highest-index port wins.
- Reads (combinational):
  - If any enabled write port targets rd_addr (!=0) in the same cycle, rd_data is the winning write's data (highest index). Otherwise rd_data is the array contents.
  - rd_busy = busy[addr] AND NOT (a same-cycle write hits addr AND issue_en/issue_rd does not also target addr).
  - Busy is never forwarded from the same-cycle issue_en; a new issue becomes visible on rd_busy from the next cycle.
- Busy update at the edge, in priority order, highest first:
  - flush: all busy<=0. Same-cycle writes still commit data; the same-cycle issue is dropped.
  - issue_en to addr A (!=0): busy[A]<=1. This wins over a same-cycle write to A, because a new producer supersedes the old one.
  - An enabled write to addr A: busy[A]<=0.
- Write-back of a non-busy register is legal; data commits and busy stays 0.
- Widths: no arithmetic on data. Addresses are used unmodified; NREGS is a power of two, so there is no out-of-range case.

Test Plan:
- Sweep: preload array with 0xDEADBEEF via backdoor, release reset, hold all inputs → ready=0 for 32 cycles, ready=1 on edge 32, all 32 reads return 0. Re-assert reset at cycle 10 → ready=0 and sweep restarts from entry 0.
- Write/bypass: wr_en[0]=1, addr 5, data 0x11223344, with rd_addr[0]=5 in the same cycle → rd_data[0]=0x11223344 combinationally and stays so next cycle. Then write addr 0 with 0xFFFFFFFF → read of 0 returns 0.
- Port collision: same cycle wr port0 addr 7=0xAAAA0000 and port1 addr 7=0x0000BBBB → bypass and next-cycle read both return 0x0000BBBB.
- Scoreboard:
  - issue_en, rd=9 → rd_busy=1 next cycle.
  - Write to 9 with 0x5 → rd_busy=0 in that same cycle (bypass), and 0 afterwards.
  - Same-cycle issue 9 plus write 9 → data=new value, busy=1 after the edge.
- Flush: mark regs 3, 4, 12 busy, then pulse flush together with issue_rd=6 and a write to 4 of 0x77 → busy all 0 (including 6), reg4=0x77.
- Gating: before ready, issue_en to 3 and a write to 3 of 0x99 → after the sweep, reg3=0 and rd_busy=0.

Source files
------------

// File: rtl/regfile_sb.sv
// Multi-port integer register file with a per-register busy scoreboard.
// After reset it zero-sweeps the whole array before raising ready.
module regfile_sb #(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned NREGS = 32,
  parameter  int unsigned NRD   = 2,
  parameter  int unsigned NWR   = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_rd,
  input  logic                 flush,
  output logic                 ready
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_nxt;
  logic [AW-1:0]     cnt_q, cnt_nxt;
  logic [NREGS-1:0]  busy_q, busy_nxt;
  logic [XLEN-1:0]   mem [NREGS];
  logic              run;

  logic [NRD-1:0]    hit;
  logic [NRD-1:0]    iss_hit;
  logic [XLEN-1:0]   byp [NRD];

  assign run = (state_q == RUN);

  // State, sweep counter, scoreboard and ready registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= '0;
      ready   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      busy_q  <= busy_nxt;
      ready   <= (state_nxt == RUN);
    end
  end

  // Sweep sequencing
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_nxt = cnt_q + AW'(1);
        if (cnt_q == AW'(NREGS - 1)) state_nxt = RUN;
      end
      RUN: state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  // Storage: zero-sweep while clearing, otherwise highest write port wins
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] != '0))
          mem[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
      end
    end
  end

  // Scoreboard: flush over issue over write-back
  always_comb begin
    busy_nxt = busy_q;
    if (run) begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] != '0))
          busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
      end
      if (issue_en && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
      if (flush) busy_nxt = '0;
    end
  end

  // Read ports with same-cycle write bypass; a concurrent re-issue keeps busy
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    hit     = '0;
    iss_hit = '0;
    for (int r = 0; r < NRD; r++) begin
      byp[r] = mem[rd_addr[r*AW +: AW]];
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[r*AW +: AW])) begin
          hit[r] = 1'b1;
          byp[r] = wr_data[w*XLEN +: XLEN];
        end
      end
      iss_hit[r] = issue_en && (issue_rd == rd_addr[r*AW +: AW]);
      if (run && (rd_addr[r*AW +: AW] != '0)) begin
        rd_data[r*XLEN +: XLEN] = byp[r];
        rd_busy[r] = busy_q[rd_addr[r*AW +: AW]] & ~(hit[r] & ~iss_hit[r]);
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: sweep timing, gating, bypass, collisions,
// scoreboard and flush, using a vector table plus hand-written sequences.
module tb_regfile_sb;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD = 2;
  localparam int unsigned NWR = 2;
  localparam int unsigned AW = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                issue_en;
  logic [AW-1:0]       issue_rd;
  logic                flush;
  logic                ready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .reset(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush), .ready(ready)
  );

  typedef struct {
    logic [AW-1:0] ra0, ra1;
    logic [1:0]    we;
    logic [AW-1:0] wa0, wa1;
    logic [31:0]   wd0, wd1;
    logic          ie;
    logic [AW-1:0] ir;
    logic          fl;
    logic [31:0]   ed0, ed1;
    logic          eb0, eb1;
  } vec_t;

  localparam int NV = 23;
  vec_t vt [NV];

  function automatic vec_t mk(input int ra0, input int ra1, input int we,
                              input int wa0, input int wa1,
                              input logic [31:0] wd0, input logic [31:0] wd1,
                              input int ie, input int ir, input int fl,
                              input logic [31:0] ed0, input logic [31:0] ed1,
                              input int eb0, input int eb1);
    vec_t v;
    v.ra0 = AW'(ra0); v.ra1 = AW'(ra1); v.we = 2'(we);
    v.wa0 = AW'(wa0); v.wa1 = AW'(wa1); v.wd0 = wd0; v.wd1 = wd1;
    v.ie = 1'(ie); v.ir = AW'(ir); v.fl = 1'(fl);
    v.ed0 = ed0; v.ed1 = ed1; v.eb0 = 1'(eb0); v.eb1 = 1'(eb1);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_rd = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr = '0;
    idle();
    // Vector table, applied once the file is swept and ready
    vt[0]  = mk(5, 0, 1, 5, 0, 32'h11223344, 0,            0, 0, 0, 32'h11223344, 0, 0, 0);
    vt[1]  = mk(5, 5, 0, 0, 0, 0, 0,                       0, 0, 0, 32'h11223344, 32'h11223344, 0, 0);
    vt[2]  = mk(0, 5, 1, 0, 0, 32'hFFFFFFFF, 0,            0, 0, 0, 0, 32'h11223344, 0, 0);
    vt[3]  = mk(0, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 0);
    vt[4]  = mk(7, 7, 3, 7, 7, 32'hAAAA0000, 32'h0000BBBB, 0, 0, 0, 32'h0000BBBB, 32'h0000BBBB, 0, 0);
    vt[5]  = mk(7, 5, 0, 0, 0, 0, 0,                       0, 0, 0, 32'h0000BBBB, 32'h11223344, 0, 0);
    vt[6]  = mk(9, 7, 0, 0, 0, 0, 0,                       1, 9, 0, 0, 32'h0000BBBB, 0, 0);
    vt[7]  = mk(9, 9, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 1, 1);
    vt[8]  = mk(9, 9, 1, 9, 0, 32'h5, 0,                   0, 0, 0, 32'h5, 32'h5, 0, 0);
    vt[9]  = mk(9, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 32'h5, 0, 0, 0);
    vt[10] = mk(9, 9, 2, 0, 9, 0, 32'h66,                  1, 9, 0, 32'h66, 32'h66, 0, 0);
    vt[11] = mk(9, 9, 0, 0, 0, 0, 0,                       0, 0, 0, 32'h66, 32'h66, 1, 1);
    vt[12] = mk(9, 9, 1, 9, 0, 32'h77, 0,                  1, 9, 0, 32'h77, 32'h77, 1, 1);
    vt[13] = mk(9, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 32'h77, 0, 1, 0);
    vt[14] = mk(3, 4, 0, 0, 0, 0, 0,                       1, 3, 0, 0, 0, 0, 0);
    vt[15] = mk(3, 4, 0, 0, 0, 0, 0,                       1, 4, 0, 0, 0, 1, 0);
    vt[16] = mk(3, 4, 0, 0, 0, 0, 0,                       1, 12, 0, 0, 0, 1, 1);
    vt[17] = mk(4, 12, 1, 4, 0, 32'h77, 0,                 1, 6, 1, 32'h77, 0, 0, 1);
    vt[18] = mk(6, 12, 0, 0, 0, 0, 0,                      0, 0, 0, 0, 0, 0, 0);
    vt[19] = mk(4, 3, 0, 0, 0, 0, 0,                       0, 0, 0, 32'h77, 0, 0, 0);
    vt[20] = mk(9, 4, 0, 0, 0, 0, 0,                       1, 0, 0, 32'h77, 32'h77, 0, 0);
    vt[21] = mk(0, 9, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 32'h77, 0, 0);
    vt[22] = mk(8, 9, 1, 8, 0, 32'hCAFE0008, 0,            0, 0, 0, 32'hCAFE0008, 32'h77, 0, 0);

    // Reset state, with gating inputs held through the whole first sweep
    #12;
    set_rd(3, 9);
    chk("reset_ready", 32'(ready), 0);
    chk("reset_rd_data", rd_data[31:0], 0);
    chk("reset_rd_busy", 32'(rd_busy), 0);
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(3)}; wr_data = {32'h0, 32'h99};
    issue_en = 1'b1; issue_rd = AW'(3); flush = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk($sformatf("sweep1_ready_e%0d", k), 32'(ready), (k == 32) ? 1 : 0);
      if (k == 16) begin
        chk("clear_rd_data", rd_data[31:0], 0);
        chk("clear_rd_busy", 32'(rd_busy), 0);
      end
    end
    idle();
    #1;
    chk("gate_reg3_data", rd_data[31:0], 0);
    chk("gate_reg3_busy", 32'(rd_busy[0]), 0);

    // Fill with DEADBEEF and mark a register busy, then reset mid-sweep
    tick();
    for (int a = 1; a < 32; a++) begin
      wr_en = 2'b01; wr_addr = {AW'(0), AW'(a)}; wr_data = {32'h0, 32'hDEADBEEF};
      tick();
    end
    idle();
    issue_en = 1'b1; issue_rd = AW'(20);
    tick();
    idle();
    set_rd(17, 20);
    #1;
    chk("fill_reg17", rd_data[31:0], 32'hDEADBEEF);
    chk("fill_busy20", 32'(rd_busy[1]), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_ready", 32'(ready), 0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("mid_sweep_ready", 32'(ready), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_ready", 32'(ready), 0);
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk($sformatf("sweep2_ready_e%0d", k), 32'(ready), (k == 32) ? 1 : 0);
    end
    for (int a = 0; a < 32; a++) begin
      set_rd(a, 31 - a);
      #1;
      chk($sformatf("swept_r%0d", a), rd_data[31:0], 0);
      chk($sformatf("swept_r%0d", 31 - a), rd_data[63:32], 0);
      chk($sformatf("swept_busy_%0d", a), 32'(rd_busy), 0);
    end

    // Table-driven vectors: drive, check combinational outputs, then clock
    tick();
    for (int i = 0; i < NV; i++) begin
      rd_addr  = {vt[i].ra1, vt[i].ra0};
      wr_en    = vt[i].we;
      wr_addr  = {vt[i].wa1, vt[i].wa0};
      wr_data  = {vt[i].wd1, vt[i].wd0};
      issue_en = vt[i].ie;
      issue_rd = vt[i].ir;
      flush    = vt[i].fl;
      #2;
      chk($sformatf("v%0d_rd_data0", i), rd_data[31:0], vt[i].ed0);
      chk($sformatf("v%0d_rd_data1", i), rd_data[63:32], vt[i].ed1);
      chk($sformatf("v%0d_rd_busy0", i), 32'(rd_busy[0]), 32'(vt[i].eb0));
      chk($sformatf("v%0d_rd_busy1", i), 32'(rd_busy[1]), 32'(vt[i].eb1));
      chk($sformatf("v%0d_ready", i), 32'(ready), 1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
